// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  logic [NUM_REQ-1:0] rot;
  int                 sum;

  // Rotate so bit k of rot is requester (ptr + k) mod NUM_REQ.
  assign rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    // Scan downward so the lowest offset from ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = int'(ptr) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        found = 1'b1;
        idx   = IW'(sum);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bounded bursts and full/almost-full back-pressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int IW        = idx_w(NUM_REQ),
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                      wr_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      full,
  input  logic                      almost_full,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      wr_enbl,
  output logic [DATA_W-1:0]         wr_data,
  output logic [IW-1:0]             owner,
  output logic                      busy
);

  arb_state_e          state;
  logic [IW-1:0]       ptr;
  logic [BW-1:0]       beats;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic                accept;
  logic                last_beat;
  logic [IW-1:0]       next_ptr;
  logic [DATA_W-1:0]   slot [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A write already in flight consumes the last slot once almost_full is seen.
  assign accept = (state == ARB_BURST) && req[owner] && !full &&
                  !(almost_full && wr_enbl) && (beats < BW'(MAX_BURST));

  assign last_beat = (beats == BW'(MAX_BURST - 1));
  assign next_ptr  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign gnt       = accept ? (NUM_REQ'(1) << owner) : '0;
  assign busy      = (state == ARB_BURST);

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      owner   <= '0;
      beats   <= '0;
      wr_enbl <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_enbl <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            owner <= pick_idx;
            beats <= '0;
            state <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (accept) begin
            wr_enbl <= 1'b1;
            wr_data <= slot[owner];
            beats   <= beats + 1'b1;
            if (last_beat) begin
              ptr   <= next_ptr;
              state <= ARB_IDLE;
            end
          end else if (!req[owner]) begin
            // Requester withdrew (possibly while blocked): nothing transferred.
            ptr   <= next_ptr;
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge wr_clk) disable iff (rst) $onehot0(gnt));
  a_no_write_full: assert property (@(posedge wr_clk) disable iff (rst) full |-> (gnt == '0));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 6;

  logic                      wr_clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic                      full = 1'b0;
  logic                      almost_full = 1'b0;
  logic [NUM_REQ-1:0]        gnt;
  logic                      wr_enbl;
  logic [DATA_W-1:0]         wr_data;
  logic [1:0]                owner;
  logic                      busy;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .wr_clk      (wr_clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .full        (full),
    .almost_full (almost_full),
    .gnt         (gnt),
    .wr_enbl     (wr_enbl),
    .wr_data     (wr_data),
    .owner       (owner),
    .busy        (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Producer queues: head is presented, popped when a transfer happens.
  logic [DATA_W-1:0] rq [NUM_REQ][$];

  // Behavioural model of the arbiter.
  bit                m_busy  = 1'b0;
  int                m_owner = 0;
  int                m_ptr   = 0;
  int                m_beats = 0;
  bit                m_we    = 1'b0;
  logic [DATA_W-1:0] m_wd    = '0;

  logic [DATA_W-1:0] wl_data [$];
  int                wl_own [$];
  int                wl_cyc [$];
  int                cyc = 0;
  logic [NUM_REQ-1:0] xfer_seen = '0;
  bit                we_seen = 1'b0;
  bit                fifo_en = 1'b0;
  int                f_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit bit_at(input logic [NUM_REQ-1:0] v, input int i);
    logic [NUM_REQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0; m_we = 1'b0; m_wd = '0;
  endfunction

  function automatic bit m_accept();
    return m_busy && bit_at(req, m_owner) && !full && !(almost_full && m_we) &&
           (m_beats < MAX_BURST);
  endfunction

  function automatic void model_step(input bit acc);
    int pick;
    pick = -1;
    if (!m_busy) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (pick < 0 && bit_at(req, (m_ptr + k) % NUM_REQ)) pick = (m_ptr + k) % NUM_REQ;
      m_we = 1'b0;
      if (pick >= 0) begin
        m_owner = pick; m_beats = 0; m_busy = 1'b1;
      end
    end else if (acc) begin
      m_we = 1'b1;
      m_wd = req_data[m_owner*DATA_W +: DATA_W];
      m_beats++;
      if (m_beats == MAX_BURST) begin
        m_busy = 1'b0; m_ptr = (m_owner + 1) % NUM_REQ;
      end
    end else begin
      m_we = 1'b0;
      if (!bit_at(req, m_owner)) begin
        m_busy = 1'b0; m_ptr = (m_owner + 1) % NUM_REQ;
      end
    end
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge wr_clk) begin
    logic [NUM_REQ-1:0] eg;
    if (rst) model_reset();
    eg = m_accept() ? (NUM_REQ'(1) << m_owner) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("wr_enbl", 32'(wr_enbl), 32'(m_we));
    chk("wr_data", 32'(wr_data), 32'(m_wd));
    chk("owner", 32'(owner), m_owner);
    chk("busy", 32'(busy), 32'(m_busy));
    xfer_seen = req & gnt;
    we_seen   = wr_enbl;
    if (wr_enbl && !rst) begin
      wl_data.push_back(wr_data);
      wl_own.push_back(int'(owner));
      wl_cyc.push_back(cyc);
    end
    if (!rst) model_step(eg != '0);
  end

  function automatic void apply_req();
    logic [NUM_REQ-1:0] nr;
    nr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      nr = {(rq[i].size() > 0), nr[NUM_REQ-1:1]};
      req_data[i*DATA_W +: DATA_W] = (rq[i].size() > 0) ? rq[i][0] : '0;
    end
    req = nr;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void clear_log();
    wl_data.delete(); wl_own.delete(); wl_cyc.delete();
  endfunction

  task automatic tick();
    @(posedge wr_clk);
    #1;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++)
      if (bit_at(xfer_seen, i) && rq[i].size() > 0) rq[i].delete(0);
    if (fifo_en) begin
      if (we_seen) begin
        chk("no_overflow", 32'(f_cnt < DEPTH), 32'd1);
        f_cnt++;
      end
      if (f_cnt > 0 && $urandom_range(0, 2) == 0) f_cnt--;
      full        = (f_cnt >= DEPTH);
      almost_full = (f_cnt == DEPTH - 1);
    end
    apply_req();
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((busy || wr_enbl || any_pending()) && n < bound) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= bound) begin
      n_fail++;
      $display("FAIL drain_timeout: waited %0d cycles, limit %0d", n, bound);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    int n;
    apply_req();
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_wr_enbl", 32'(wr_enbl), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single requester, three beats.
    clear_log();
    rq[1].push_back(8'h11); rq[1].push_back(8'h22); rq[1].push_back(8'h33);
    apply_req();
    tick();
    #1 chk("t1_gnt_latency", 32'(gnt), 32'b0010);
    tick();
    #1 chk("t1_we_latency", 32'(wr_enbl), 32'd1);
    chk("t1_first_data", 32'(wr_data), 32'h11);
    wait_drain(30);
    chk("t1_count", wl_data.size(), 3);
    if (wl_data.size() == 3) begin
      chk("t1_d0", 32'(wl_data[0]), 32'h11);
      chk("t1_d1", 32'(wl_data[1]), 32'h22);
      chk("t1_d2", 32'(wl_data[2]), 32'h33);
      chk("t1_contig", wl_cyc[2] - wl_cyc[0], 2);
    end
    chk("t1_owner", 32'(owner), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);

    // All four requesting: bursts 0,1,2,3 of four beats, then singles.
    do_reset();
    clear_log();
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 5; k++) rq[i].push_back(8'(i * 16 + k));
    apply_req();
    wait_drain(200);
    chk("t2_count", wl_data.size(), 20);
    for (int j = 0; j < 20; j++) begin
      if (j < wl_data.size()) begin
        n = (j < 16) ? j / 4 : j - 16;
        chk("t2_owner", wl_own[j], n);
        chk("t2_data", 32'(wl_data[j]), 32'(n * 16 + ((j < 16) ? j % 4 : 4)));
      end
    end
    if (wl_cyc.size() >= 5) chk("t2_bubble", wl_cyc[4] - wl_cyc[3], 2);

    // Full for five cycles mid-burst.
    clear_log();
    for (int k = 0; k < 4; k++) rq[0].push_back(8'(8'hA0 + k));
    apply_req();
    tick();
    tick();
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t3_gnt_blocked", 32'(gnt), 32'd0);
      if (k > 0) chk("t3_we_blocked", 32'(wr_enbl), 32'd0);
      tick();
    end
    full = 1'b0;
    #1 chk("t3_resume", 32'(gnt), 32'b0001);
    wait_drain(30);
    chk("t3_count", wl_data.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < wl_data.size()) chk("t3_data", 32'(wl_data[k]), 32'(8'hA0 + k));

    // almost_full while a write is in flight.
    clear_log();
    for (int k = 0; k < 4; k++) rq[2].push_back(8'(8'hB0 + k));
    apply_req();
    tick();
    tick();
    tick();
    almost_full = 1'b1;
    #1 chk("t4_inflight", 32'(wr_enbl), 32'd1);
    chk("t4_af_guard", 32'(gnt), 32'd0);
    tick();
    #1 chk("t4_af_accept", 32'(gnt), 32'b0100);
    almost_full = 1'b0;
    wait_drain(30);
    chk("t4_count", wl_data.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < wl_data.size()) chk("t4_data", 32'(wl_data[k]), 32'(8'hB0 + k));

    // Owner 2 withdraws after two beats; requester 3 then beats requester 0.
    clear_log();
    rq[2].push_back(8'hC0); rq[2].push_back(8'hC1);
    apply_req();
    wait_drain(30);
    chk("t5_count", wl_data.size(), 2);
    if (wl_own.size() > 0) chk("t5_owner", wl_own[0], 2);
    clear_log();
    rq[0].push_back(8'hD0); rq[3].push_back(8'hE0);
    apply_req();
    wait_drain(30);
    chk("t5_arb_count", wl_data.size(), 2);
    if (wl_data.size() == 2) begin
      chk("t5_first_owner", wl_own[0], 3);
      chk("t5_first_data", 32'(wl_data[0]), 32'hE0);
      chk("t5_second_owner", wl_own[1], 0);
    end

    // Reset at beat two of a burst.
    clear_log();
    for (int k = 0; k < 4; k++) rq[3].push_back(8'(8'hF0 + k));
    apply_req();
    n = 0;
    while (wl_data.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_reached_beat2", 32'(wl_data.size()), 32'd2);
    rst = 1'b1;
    #1 chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_we", 32'(wr_enbl), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    clear_log();
    rq[0].push_back(8'h55);
    apply_req();
    wait_drain(40);
    if (wl_own.size() >= 2) begin
      chk("t6_restart_owner", wl_own[0], 0);
      chk("t6_restart_data", 32'(wl_data[0]), 32'h55);
      chk("t6_next_owner", wl_own[1], 3);
    end else begin
      chk("t6_restart_count", wl_own.size(), 2);
    end

    // Random traffic under back-pressure from a modelled FIFO.
    clear_log();
    pushed  = 0;
    f_cnt   = 0;
    fifo_en = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() < 6 && $urandom_range(0, 3) == 0) begin
          rq[i].push_back(8'($urandom));
          pushed++;
        end
      end
      apply_req();
    end
    wait_drain(2000);
    chk("rand_no_loss", wl_data.size(), pushed);
    fifo_en = 1'b0;
    full = 1'b0;
    almost_full = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
